instruction_fetch_unit: RTL and testbench

Parametrised, synthesizable instruction-fetch front end for the LEGv8 `Processor`. It replaces the hand-driven instruction stimulus used in control testing. It holds a loadable instruction memory and a fetch PC, and prefetches words into a small FIFO. Words reach the processor's `instruction` input through a valid/ready handshake. It predicts unconditional `B` as taken internally, accepts redirects for resolved `CBZ`/mispredicts, and flags fetch faults.

---
 rtl/instruction_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: a loadable instruction memory, a fetch PC and a prefetch FIFO
// that feeds the processor through valid/ready. Unconditional B is predicted taken; redirects flush.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | not issuing reads; memory may be loaded; FIFO contents kept
// S_FETCH | issuing one read per cycle while the FIFO has room
// S_FAULT | fetch PC misaligned or out of range; waits for a redirect
module instruction_fetch_unit #(
    parameter int                    PC_WIDTH   = 64,
    parameter int                    MEM_DEPTH  = 256,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          load_en,
    input  logic [$clog2(MEM_DEPTH)-1:0]  load_addr,
    input  logic [31:0]                   load_data,
    input  logic                          run,
    output logic [31:0]                   instr_out,
    output logic [PC_WIDTH-1:0]           instr_pc,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    input  logic                          redirect_valid,
    input  logic [PC_WIDTH-1:0]           redirect_target,
    output logic                          fault
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FAULT} state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   rd_pc_q, rd_pc_d;
    logic                  inflight_q, inflight_d;
    logic [FW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [FW:0]           count_q, count_d;
    logic                  fault_q, fault_d;

    logic [31:0]           mem [MEM_DEPTH];
    logic [31:0]           rdata_q;
    logic [31:0]           fifo_instr [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]   fifo_pc [FIFO_DEPTH];

    logic                  valid, pop, push, b_taken, pc_bad, can_issue, issue, fault_hit;
    logic [FW:0]           occ;
    logic [PC_WIDTH-1:0]   b_target;

    // A redirect overrides every other same-cycle FIFO or PC action.
    assign valid     = (count_q != '0);
    assign pop       = valid & instr_ready & ~redirect_valid;
    assign push      = inflight_q & ~redirect_valid;
    assign b_taken   = push & (rdata_q[31:26] == 6'b000101);
    assign b_target  = rd_pc_q + {{(PC_WIDTH-28){rdata_q[25]}}, rdata_q[25:0], 2'b00};
    assign occ       = count_q + {{FW{1'b0}}, inflight_q};
    assign pc_bad    = (pc_q[1:0] != 2'b00) | (pc_q[PC_WIDTH-1:AW+2] != '0);
    // The wrong-path read behind a taken B is simply never issued.
    assign can_issue = (state_q == S_FETCH) & run & ~redirect_valid & ~b_taken
                       & (occ < (FW+1)'(FIFO_DEPTH));
    assign issue     = can_issue & ~pc_bad;
    assign fault_hit = can_issue & pc_bad;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rd_pc_d    = rd_pc_q;
        inflight_d = issue;
        wr_ptr_d   = wr_ptr_q + FW'(push);
        rd_ptr_d   = rd_ptr_q + FW'(pop);
        count_d    = count_q + (FW+1)'(push) - (FW+1)'(pop);

        case (state_q)
            S_IDLE:  if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (!run)           state_d = S_IDLE;
                else if (fault_hit) state_d = S_FAULT;
            end
            S_FAULT: if (redirect_valid && run) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            rd_pc_d = pc_q;
            pc_d    = pc_q + PC_WIDTH'(4);
        end
        if (b_taken)
            pc_d = b_target;
        if (redirect_valid) begin
            pc_d     = redirect_target;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        fault_d = (state_d == S_FAULT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            rd_pc_q    <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rd_pc_q    <= rd_pc_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
        end
    end

    // Storage is deliberately left out of reset so program contents survive it.
    always_ff @(posedge clock) begin
        if (load_en && state_q == S_IDLE)
            mem[load_addr] <= load_data;
        if (issue)
            rdata_q <= mem[pc_q[AW+1:2]];
        if (push) begin
            fifo_instr[wr_ptr_q] <= rdata_q;
            fifo_pc[wr_ptr_q]    <= rd_pc_q;
        end
    end

    assign instr_valid = valid;
    assign instr_out   = valid ? fifo_instr[rd_ptr_q] : '0;
    assign instr_pc    = valid ? fifo_pc[rd_ptr_q] : '0;
    assign fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: per-cycle vector tables with hand-derived
// expectations, plus hand-written reset sequences.
module tb_instruction_fetch_unit;

    localparam logic [31:0] I_ADD = 32'h8B030041;
    localparam logic [31:0] I_SUB = 32'hCB030041;
    localparam logic [31:0] I_AND = 32'h8A030041;
    localparam logic [31:0] I_ORR = 32'hAA030041;
    localparam logic [31:0] I_B2  = 32'h14000002;
    localparam logic [31:0] I_B1  = 32'h14000001;
    localparam logic [31:0] I_CBZ = 32'hB4080000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic        run = 1'b0;
    logic [31:0] instr_out;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_target = '0;
    logic        fault;

    instruction_fetch_unit #(
        .PC_WIDTH(64), .MEM_DEPTH(256), .FIFO_DEPTH(4), .RESET_PC(64'h0)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .run(run),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .fault(fault)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ready;
        logic        redir;
        logic [63:0] target;
        logic        exp_valid;
        logic [63:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[$];
    int   seg[5];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] word_w(input int i);
        return 32'hD2800000 | 32'(i);
    endfunction

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return I_ADD;
            1:       return I_SUB;
            2:       return I_AND;
            3:       return I_ORR;
            default: return word_w(i);
        endcase
    endfunction

    function automatic void add(input logic ready, input logic redir, input logic [63:0] tgt,
                                input logic v, input logic [63:0] pc, input logic [31:0] ins,
                                input logic f);
        vec_t t;
        t.ready = ready; t.redir = redir; t.target = tgt;
        t.exp_valid = v; t.exp_pc = pc; t.exp_instr = ins; t.exp_fault = f;
        vecs.push_back(t);
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        n_vec++;
        cmp({tag, " valid"}, 64'(instr_valid), 64'd0);
        cmp({tag, " instr"}, 64'(instr_out), 64'd0);
        cmp({tag, " pc"}, instr_pc, 64'd0);
        cmp({tag, " fault"}, 64'(fault), 64'd0);
    endtask

    task automatic apply_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            instr_ready     = vecs[i].ready;
            redirect_valid  = vecs[i].redir;
            redirect_target = vecs[i].target;
            @(posedge clock);
            #1;
            n_vec++;
            cmp($sformatf("v%0d valid", i), 64'(instr_valid), 64'(vecs[i].exp_valid));
            cmp($sformatf("v%0d fault", i), 64'(fault), 64'(vecs[i].exp_fault));
            if (vecs[i].exp_valid) begin
                cmp($sformatf("v%0d pc", i), instr_pc, vecs[i].exp_pc);
                cmp($sformatf("v%0d instr", i), 64'(instr_out), 64'(vecs[i].exp_instr));
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic load(input int addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = 8'(addr);
        load_data = data;
        @(posedge clock);
        #1;
        load_en = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        run = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; load_en = 1'b0;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check_reset(tag);
        reset_n = 1'b1;
    endtask

    initial begin
        // Straight-line stream, then a 10-cycle stall and release.
        seg[0] = vecs.size();
        for (int k = 0; k < 2; k++)  add(1, 0, 0, 0, 0, 0, 0);
        for (int k = 2; k < 6; k++)  add(1, 0, 0, 1, 64'(4*(k-2)), init_word(k-2), 0);
        for (int k = 6; k < 16; k++) add(0, 0, 0, 1, 64'd12, I_ORR, 0);
        for (int k = 16; k < 23; k++) add(1, 0, 0, 1, 64'(16 + 4*(k-16)), word_w(4 + (k-16)), 0);

        // Taken B at PC 4 jumping to 12: one empty slot, PC 8 never shown.
        seg[1] = vecs.size();
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 64'd0, I_ADD, 0);
        add(1, 0, 0, 1, 64'd4, I_B2, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 64'd12, I_ORR, 0);
        add(1, 0, 0, 1, 64'd16, word_w(4), 0);
        add(1, 0, 0, 1, 64'd20, word_w(5), 0);

        // CBZ redirect, misaligned-target fault and recovery, then B into an out-of-range PC.
        seg[2] = vecs.size();
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 64'd0, I_ADD, 0);
        add(1, 0, 0, 1, 64'd4, I_SUB, 0);
        add(1, 0, 0, 1, 64'd8, I_CBZ, 0);
        add(1, 1, 64'd0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 64'd0, I_ADD, 0);
        add(1, 0, 0, 1, 64'd4, I_SUB, 0);
        add(1, 1, 64'd3, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 64'd0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 64'd0, I_ADD, 0);
        add(1, 0, 0, 1, 64'd4, I_SUB, 0);
        add(0, 1, 64'h3FC, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 64'h3FC, I_B1, 0);
        add(0, 0, 0, 1, 64'h3FC, I_B1, 1);
        add(1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 64'h400, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 64'd12, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 64'd12, I_ORR, 0);
        add(1, 0, 0, 1, 64'd16, word_w(4), 0);

        // Restart after an asynchronous reset: memory contents must have survived.
        seg[3] = vecs.size();
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 64'd0, I_ADD, 0);
        add(1, 0, 0, 1, 64'd4, I_SUB, 0);
        add(1, 0, 0, 1, 64'd8, I_CBZ, 0);
        seg[4] = vecs.size();

        repeat (2) @(posedge clock);
        #1;
        check_reset("por");
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) load(i, init_word(i));
        load(255, I_B1);

        run = 1'b1;
        apply_range(seg[0], seg[1]);

        do_reset("reset_b");
        load(1, I_B2);
        run = 1'b1;
        apply_range(seg[1], seg[2]);

        do_reset("reset_cbz");
        load(1, I_SUB);
        load(2, I_CBZ);
        run = 1'b1;
        apply_range(seg[2], seg[3]);

        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset("async");
        run = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        run = 1'b1;
        apply_range(seg[3], seg[4]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
